pipe_fetch: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage pipelined MIPS CPU with IO. Holds the PC and fetches from instruction memory over a req/ready handshake that tolerates wait states. Delivers `inst`/`dpc4` to the decode stage and obeys decode's stall (`wpcir`) and redirect (`pcsource`, `bpc`, `da`, `jpc`). Taken control transfers squash the sequential fetch; there is no delay slot and no prediction.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_fetch_npc.sv | 34 +++
 rtl/pipe_fetch.sv | 226 ++++++++++++++++++++++
 tb/tb_pipe_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipelined MIPS front end.
// Holds the pcsource encodings, the nop instruction word and the
// fetch-stage state enumeration used by pipe_fetch.
package pipe_pkg;

  // pcsource encodings driven by the decode stage
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  // sll $0,$0,0 -- the bubble placed into IF/ID
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // FETCH: request outstanding; HOLD: word parked while decode stalls;
  // DRAIN: redirected mid-request, waiting to discard the old response
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    DRAIN = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pipe_fetch_npc.sv
// pipe_fetch_npc: combinational next-PC selection.
// Ports:
//   pc        in  32  current fetch PC
//   pcsource  in  2   00 seq, 01 branch, 10 jr, 11 j/jal
//   bpc/da/jpc in 32  redirect targets
//   pc4       out 32  pc + 4 (wraps mod 2^32, low bits pass through)
//   npc       out 32  target selected by pcsource
module pipe_fetch_npc
  import pipe_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  output logic [31:0] pc4,
  output logic [31:0] npc
);

  assign pc4 = pc + 32'd4;

  // select the next PC by pcsource
  always_comb begin
    npc = pc4;
    case (pcsource)
      PCSRC_SEQ: npc = pc4;
      PCSRC_BR:  npc = bpc;
      PCSRC_JR:  npc = da;
      PCSRC_J:   npc = jpc;
      default:   npc = pc4;
    endcase
  end

endmodule

// File: rtl/pipe_fetch.sv
// pipe_fetch: instruction-fetch stage plus IF/ID pipeline register.
// Fetches from instruction memory over a req/ready handshake with wait
// states, obeys decode stall (wpcir) and redirects (pcsource). Taken
// transfers squash the sequential fetch; no delay slot, no prediction.
// Optional feature macro: PIPE_FETCH_PERF_EN adds three saturating
// counters (perf_fetched, perf_squashed, perf_wait).
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   wpcir                1 = decode accepts, 0 = decode stalls
//   pcsource, bpc, da, jpc  redirect control and targets
//   imem_req/imem_addr   fetch request and address (addr == pc)
//   imem_rdata/imem_ready  memory response
//   pc                   current fetch PC
//   inst, dpc4, dvalid   IF/ID register contents
//   perf_*               performance counters (PIPE_FETCH_PERF_EN only)
module pipe_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
`ifdef PIPE_FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed,
  output logic [31:0] perf_wait,
`endif
  output logic        dvalid
);

  fetch_state_e state_r, state_nx_s;
  logic [31:0]  pc_r, pc_nx_s;
  logic [31:0]  inst_r, inst_nx_s;
  logic [31:0]  dpc4_r, dpc4_nx_s;
  logic         dvalid_r, dvalid_nx_s;
  logic [31:0]  hold_r, hold_nx_s;
  logic [31:0]  rd_target_r, rd_target_nx_s;
  logic         req_r, req_nx_s;
  logic [31:0]  pc4_s, npc_s;
  logic         redir_s, resp_s;
  logic         load_valid_s, load_squash_s;

  pipe_fetch_npc u_npc (
    .pc       (pc_r),
    .pcsource (pcsource),
    .bpc      (bpc),
    .da       (da),
    .jpc      (jpc),
    .pc4      (pc4_s),
    .npc      (npc_s)
  );

  assign redir_s = wpcir & (pcsource != PCSRC_SEQ);
  // a response only counts while a request is actually being presented
  assign resp_s  = req_r & imem_ready;

  // next-state, PC and IF/ID selection
  always_comb begin
    state_nx_s     = state_r;
    pc_nx_s        = pc_r;
    inst_nx_s      = inst_r;
    dpc4_nx_s      = dpc4_r;
    dvalid_nx_s    = dvalid_r;
    hold_nx_s      = hold_r;
    rd_target_nx_s = rd_target_r;
    load_valid_s   = 1'b0;
    load_squash_s  = 1'b0;
    case (state_r)
      FETCH: begin
        if (resp_s) begin
          if (redir_s) begin
            inst_nx_s     = NOP_INST;
            dvalid_nx_s   = 1'b0;
            pc_nx_s       = npc_s;
            load_squash_s = 1'b1;
          end else if (wpcir) begin
            inst_nx_s    = imem_rdata;
            dpc4_nx_s    = pc4_s;
            dvalid_nx_s  = 1'b1;
            pc_nx_s      = pc4_s;
            load_valid_s = 1'b1;
          end else begin
            hold_nx_s  = imem_rdata;
            state_nx_s = HOLD;
          end
        end else begin
          if (redir_s) begin
            inst_nx_s     = NOP_INST;
            dvalid_nx_s   = 1'b0;
            load_squash_s = 1'b1;
            // with a request in flight the address must stay put until the
            // old response arrives; otherwise the PC can move at once
            if (req_r) begin
              rd_target_nx_s = npc_s;
              state_nx_s     = DRAIN;
            end else begin
              pc_nx_s = npc_s;
            end
          end else if (wpcir) begin
            inst_nx_s   = NOP_INST;
            dvalid_nx_s = 1'b0;
          end else begin
            state_nx_s = FETCH;
          end
        end
      end
      HOLD: begin
        if (!wpcir) begin
          state_nx_s = HOLD;
        end else if (redir_s) begin
          inst_nx_s     = NOP_INST;
          dvalid_nx_s   = 1'b0;
          pc_nx_s       = npc_s;
          load_squash_s = 1'b1;
          state_nx_s    = FETCH;
        end else begin
          inst_nx_s    = hold_r;
          dpc4_nx_s    = pc4_s;
          dvalid_nx_s  = 1'b1;
          pc_nx_s      = pc4_s;
          load_valid_s = 1'b1;
          state_nx_s   = FETCH;
        end
      end
      DRAIN: begin
        if (redir_s) begin
          rd_target_nx_s = npc_s;
          load_squash_s  = 1'b1;
        end else begin
          rd_target_nx_s = rd_target_r;
        end
        if (wpcir) begin
          inst_nx_s   = NOP_INST;
          dvalid_nx_s = 1'b0;
        end else begin
          dvalid_nx_s = dvalid_r;
        end
        // the stale response is discarded; the latest target wins
        if (resp_s) begin
          pc_nx_s    = redir_s ? npc_s : rd_target_r;
          state_nx_s = FETCH;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      default: begin
        state_nx_s = FETCH;
      end
    endcase
    req_nx_s = (state_nx_s != HOLD);
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= FETCH;
      pc_r        <= RESET_PC;
      inst_r      <= NOP_INST;
      dpc4_r      <= 32'h0000_0000;
      dvalid_r    <= 1'b0;
      hold_r      <= 32'h0000_0000;
      rd_target_r <= 32'h0000_0000;
      req_r       <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      pc_r        <= pc_nx_s;
      inst_r      <= inst_nx_s;
      dpc4_r      <= dpc4_nx_s;
      dvalid_r    <= dvalid_nx_s;
      hold_r      <= hold_nx_s;
      rd_target_r <= rd_target_nx_s;
      req_r       <= req_nx_s;
    end
  end

  assign imem_req  = req_r;
  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign inst      = inst_r;
  assign dpc4      = dpc4_r;
  assign dvalid    = dvalid_r;

`ifdef PIPE_FETCH_PERF_EN
  logic [31:0] perf_fetched_r, perf_squashed_r, perf_wait_r;

  // saturating performance counters
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_r  <= 32'h0000_0000;
      perf_squashed_r <= 32'h0000_0000;
      perf_wait_r     <= 32'h0000_0000;
    end else begin
      if (load_valid_s && (perf_fetched_r != 32'hFFFF_FFFF)) begin
        perf_fetched_r <= perf_fetched_r + 32'd1;
      end
      if (load_squash_s && (perf_squashed_r != 32'hFFFF_FFFF)) begin
        perf_squashed_r <= perf_squashed_r + 32'd1;
      end
      if (req_r && !imem_ready && (perf_wait_r != 32'hFFFF_FFFF)) begin
        perf_wait_r <= perf_wait_r + 32'd1;
      end
    end
  end

  assign perf_fetched  = perf_fetched_r;
  assign perf_squashed = perf_squashed_r;
  assign perf_wait     = perf_wait_r;
`else
  logic unused_perf_s;
  assign unused_perf_s = load_valid_s ^ load_squash_s;
`endif

endmodule

// File: tb/tb_pipe_fetch.sv
// tb_pipe_fetch: directed self-checking bench for pipe_fetch.
module tb_pipe_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wpcir = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = 32'h0;
  logic [31:0] da = 32'h0;
  logic [31:0] jpc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc, inst, dpc4;
  logic        dvalid;
  logic        rdy_en = 1'b1;
`ifdef PIPE_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_squashed, perf_wait;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  assign imem_rdata = word(imem_addr);
  assign imem_ready = imem_req & rdy_en;

  pipe_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .wpcir(wpcir), .pcsource(pcsource),
    .bpc(bpc), .da(da), .jpc(jpc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .pc(pc), .inst(inst), .dpc4(dpc4),
`ifdef PIPE_FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_squashed(perf_squashed), .perf_wait(perf_wait),
`endif
    .dvalid(dvalid)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wpcir = 1'b1; pcsource = 2'b00; rdy_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; wpcir = 1'b1; pcsource = 2'b00; rdy_en = 1'b1;
    tick(); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if ({dvalid, inst, dpc4} !== 65'h0) begin errors++; $display("FAIL reset_ifid: got %b/%h/%h expected 0/0/0", dvalid, inst, dpc4); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    reset = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL reset_release: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      tick();
      checks++;
      if (dvalid !== 1'b1 || inst !== word(a) || dpc4 !== a + 32'd4) begin
        errors++; $display("FAIL seq_%0d: got v=%b inst=%h dpc4=%h expected v=1 inst=%h dpc4=%h", i, dvalid, inst, dpc4, word(a), a + 32'd4);
      end
    end
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL seq_pc: got %h expected %h", pc, 32'h10); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    wpcir = 1'b0;
    tick();
    checks++; if (inst !== word(32'h4) || dpc4 !== 32'h8 || pc !== 32'h8 || imem_req !== 1'b0) begin
      errors++; $display("FAIL stall_1: got inst=%h dpc4=%h pc=%h req=%b expected %h/8/8/0", inst, dpc4, pc, imem_req, word(32'h4)); end
    tick();
    checks++; if (inst !== word(32'h4) || imem_req !== 1'b0 || dvalid !== 1'b1) begin
      errors++; $display("FAIL stall_2: got inst=%h req=%b v=%b expected %h/0/1", inst, imem_req, dvalid, word(32'h4)); end
    wpcir = 1'b1;
    tick();
    checks++; if (inst !== word(32'h8) || dpc4 !== 32'hC || pc !== 32'hC || imem_req !== 1'b1) begin
      errors++; $display("FAIL stall_release: got inst=%h dpc4=%h pc=%h req=%b expected %h/C/C/1", inst, dpc4, pc, imem_req, word(32'h8)); end
    tick();
    checks++; if (inst !== word(32'hC) || dpc4 !== 32'h10) begin
      errors++; $display("FAIL stall_next: got inst=%h dpc4=%h expected %h/10", inst, dpc4, word(32'hC)); end
  endtask

  task automatic test_branch();
    do_reset();
    tick();
    pcsource = 2'b01; bpc = 32'h40;
    tick();
    pcsource = 2'b00;
    checks++; if (dvalid !== 1'b0 || inst !== 32'h0 || pc !== 32'h40) begin
      errors++; $display("FAIL branch_squash: got v=%b inst=%h pc=%h expected 0/0/40", dvalid, inst, pc); end
    tick();
    checks++; if (dvalid !== 1'b1 || inst !== word(32'h40) || dpc4 !== 32'h44) begin
      errors++; $display("FAIL branch_target: got v=%b inst=%h dpc4=%h expected 1/%h/44", dvalid, inst, dpc4, word(32'h40)); end
  endtask

  task automatic test_drain();
    do_reset();
    tick();
    rdy_en = 1'b0; pcsource = 2'b10; da = 32'h100;
    tick();
    pcsource = 2'b00;
    checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1 || dvalid !== 1'b0) begin
      errors++; $display("FAIL drain_1: got addr=%h req=%b v=%b expected 4/1/0", imem_addr, imem_req, dvalid); end
    tick();
    checks++; if (imem_addr !== 32'h4 || dvalid !== 1'b0) begin
      errors++; $display("FAIL drain_2: got addr=%h v=%b expected 4/0", imem_addr, dvalid); end
    tick();
    checks++; if (imem_addr !== 32'h4 || dvalid !== 1'b0 || inst !== 32'h0) begin
      errors++; $display("FAIL drain_3: got addr=%h v=%b inst=%h expected 4/0/0", imem_addr, dvalid, inst); end
    rdy_en = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h100 || dvalid !== 1'b0 || inst !== 32'h0) begin
      errors++; $display("FAIL drain_drop: got addr=%h v=%b inst=%h expected 100/0/0", imem_addr, dvalid, inst); end
    tick();
    checks++; if (dvalid !== 1'b1 || inst !== word(32'h100) || dpc4 !== 32'h104) begin
      errors++; $display("FAIL drain_target: got v=%b inst=%h dpc4=%h expected 1/%h/104", dvalid, inst, dpc4, word(32'h100)); end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    tick();
    wpcir = 1'b0;
    tick();
    wpcir = 1'b1; pcsource = 2'b01; bpc = 32'h80;
    tick();
    pcsource = 2'b00;
    checks++; if (dvalid !== 1'b0 || pc !== 32'h80 || imem_req !== 1'b1) begin
      errors++; $display("FAIL hold_redir: got v=%b pc=%h req=%b expected 0/80/1", dvalid, pc, imem_req); end
    tick();
    checks++; if (inst !== word(32'h80) || dpc4 !== 32'h84 || dvalid !== 1'b1) begin
      errors++; $display("FAIL hold_redir_target: got inst=%h dpc4=%h v=%b expected %h/84/1", inst, dpc4, dvalid, word(32'h80)); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    tick();
    rdy_en = 1'b0; pcsource = 2'b11; jpc = 32'h200;
    tick();
    pcsource = 2'b00; reset = 1'b1;
    tick();
    checks++; if (pc !== 32'h0 || dvalid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_drain: got pc=%h v=%b req=%b expected 0/0/0", pc, dvalid, imem_req); end
    reset = 1'b0; rdy_en = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_drain_resume: got req=%b addr=%h expected 1/0", imem_req, imem_addr); end
    tick();
    checks++; if (dvalid !== 1'b1 || inst !== word(32'h0) || pc !== 32'h4) begin
      errors++; $display("FAIL rst_drain_fetch: got v=%b inst=%h pc=%h expected 1/%h/4", dvalid, inst, pc, word(32'h0)); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
    tick();
    pcsource = 2'b00;
    checks++; if (pc !== 32'hFFFF_FFFC || dvalid !== 1'b0) begin
      errors++; $display("FAIL wrap_jump: got pc=%h v=%b expected FFFFFFFC/0", pc, dvalid); end
    tick();
    checks++; if (imem_addr !== 32'h0 || inst !== word(32'hFFFF_FFFC) || dpc4 !== 32'h0) begin
      errors++; $display("FAIL wrap_addr: got addr=%h inst=%h dpc4=%h expected 0/%h/0", imem_addr, inst, dpc4, word(32'hFFFF_FFFC)); end
    tick();
    checks++; if (inst !== word(32'h0) || dpc4 !== 32'h4) begin
      errors++; $display("FAIL wrap_next: got inst=%h dpc4=%h expected %h/4", inst, dpc4, word(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_drain();
    test_hold_redirect();
    test_reset_in_drain();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
